// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: holds renamed micro-ops until both sources are ready
// and hands the oldest ready one to the functional unit through a registered valid/ready port.

module rs_issue_scheduler_chk #(
    parameter int RS_DEPTH = 8,
    parameter int AGE_W    = $clog2(RS_DEPTH)
) (
    input logic                      clk,
    input logic                      rst,
    input logic [RS_DEPTH-1:0]       valid,
    input logic [RS_DEPTH*AGE_W-1:0] ages,
    input logic [AGE_W:0]            occupancy
);
    function automatic int count_ones(input logic [RS_DEPTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    function automatic logic ages_unique(input logic [RS_DEPTH-1:0] v,
                                         input logic [RS_DEPTH*AGE_W-1:0] a);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = i + 1; j < RS_DEPTH; j++) begin
                if (v[i] && v[j] && (a[i*AGE_W +: AGE_W] == a[j*AGE_W +: AGE_W])) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    // Structural invariants of the entry array, checked every cycle outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (count_ones(valid) == int'(occupancy))
                else $error("rs occupancy disagrees with valid entry count");
            assert (ages_unique(valid, ages))
                else $error("rs valid entries share an age");
        end
    end
endmodule

module rs_issue_scheduler #(
    parameter int RS_DEPTH  = 8,
    parameter int PREG_W    = 6,
    parameter int ROB_IDX_W = 5,
    parameter int WB_PORTS  = 2,
    parameter int AGE_W     = $clog2(RS_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [ROB_IDX_W-1:0]       alloc_rob_id,
    input  logic [PREG_W-1:0]          alloc_rs1_phy,
    input  logic                       alloc_rs1_rdy,
    input  logic [PREG_W-1:0]          alloc_rs2_phy,
    input  logic                       alloc_rs2_rdy,
    input  logic [PREG_W-1:0]          alloc_rd_phy,
    input  logic [2:0]                 alloc_funct3,
    input  logic [6:0]                 alloc_funct7,
    input  logic [31:0]                alloc_imm,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0] wb_preg,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [ROB_IDX_W-1:0]       issue_rob_id,
    output logic [PREG_W-1:0]          issue_rs1_phy,
    output logic [PREG_W-1:0]          issue_rs2_phy,
    output logic [PREG_W-1:0]          issue_rd_phy,
    output logic [2:0]                 issue_funct3,
    output logic [6:0]                 issue_funct7,
    output logic [31:0]                issue_imm,
    output logic [AGE_W:0]             occupancy
);
    localparam logic [AGE_W:0] FULL_OCC = (AGE_W+1)'(RS_DEPTH);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_id;
        logic [PREG_W-1:0]    rs1_phy;
        logic [PREG_W-1:0]    rs2_phy;
        logic [PREG_W-1:0]    rd_phy;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [31:0]          imm;
    } payload_t;

    logic [RS_DEPTH-1:0]       valid_r;
    logic [RS_DEPTH-1:0]       rs1_rdy_r;
    logic [RS_DEPTH-1:0]       rs2_rdy_r;
    logic [AGE_W-1:0]          age_r [RS_DEPTH];
    payload_t                  pay_r [RS_DEPTH];
    payload_t                  issue_pay_r;
    logic                      issue_valid_r;
    logic [AGE_W:0]            occupancy_r;
    logic                      alloc_ready_r;

    logic                      sel_found_s;
    logic [AGE_W-1:0]          sel_idx_s;
    logic [AGE_W-1:0]          sel_age_s;
    logic [AGE_W-1:0]          free_idx_s;
    logic                      issue_load_s;
    logic                      remove_s;
    logic                      alloc_hs_s;
    logic [AGE_W:0]            occ_after_remove_s;
    logic [AGE_W:0]            occ_next_s;
    logic                      new_rs1_rdy_s;
    logic                      new_rs2_rdy_s;
    logic [RS_DEPTH*AGE_W-1:0] age_flat_s;

    function automatic logic wb_hit(input logic [PREG_W-1:0]          preg,
                                    input logic [WB_PORTS-1:0]        v,
                                    input logic [WB_PORTS*PREG_W-1:0] p);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (v[k] && (p[k*PREG_W +: PREG_W] == preg)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Oldest-ready select over registered entry state.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_age_s   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_r[i] && rs1_rdy_r[i] && rs2_rdy_r[i] &&
                (!sel_found_s || (age_r[i] < sel_age_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = AGE_W'(i);
                sel_age_s   = age_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-index free slot; scanning downward leaves the smallest index last.
    always_comb begin
        free_idx_s = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = AGE_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Handshakes, next occupancy and readiness of the incoming micro-op.
    always_comb begin
        issue_load_s       = !issue_valid_r || issue_ready;
        remove_s           = sel_found_s && issue_load_s;
        alloc_hs_s         = alloc_valid && alloc_ready_r && !flush;
        occ_after_remove_s = occupancy_r - (AGE_W+1)'(remove_s);
        occ_next_s         = occ_after_remove_s + (AGE_W+1)'(alloc_hs_s);
        new_rs1_rdy_s      = alloc_rs1_rdy || (alloc_rs1_phy == PREG_W'(0)) ||
                             wb_hit(alloc_rs1_phy, wb_valid, wb_preg);
        new_rs2_rdy_s      = alloc_rs2_rdy || (alloc_rs2_phy == PREG_W'(0)) ||
                             wb_hit(alloc_rs2_phy, wb_valid, wb_preg);
    end

    // Entry array, age bookkeeping and the issue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r       <= '0;
            rs1_rdy_r     <= '0;
            rs2_rdy_r     <= '0;
            issue_valid_r <= 1'b0;
            issue_pay_r   <= '0;
            occupancy_r   <= '0;
            alloc_ready_r <= 1'b1;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_r[i] <= '0;
                pay_r[i] <= '0;
            end
        end else if (flush) begin
            valid_r       <= '0;
            issue_valid_r <= 1'b0;
            occupancy_r   <= '0;
            alloc_ready_r <= 1'b1;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (valid_r[i]) begin
                    if (wb_hit(pay_r[i].rs1_phy, wb_valid, wb_preg)) begin
                        rs1_rdy_r[i] <= 1'b1;
                    end
                    if (wb_hit(pay_r[i].rs2_phy, wb_valid, wb_preg)) begin
                        rs2_rdy_r[i] <= 1'b1;
                    end
                    if (remove_s && (age_r[i] > sel_age_s)) begin
                        age_r[i] <= age_r[i] - AGE_W'(1);
                    end
                end
            end
            if (remove_s) begin
                valid_r[sel_idx_s] <= 1'b0;
            end
            // A slot freed this cycle is still marked valid in free_idx_s, so no overlap.
            if (alloc_hs_s) begin
                valid_r[free_idx_s]   <= 1'b1;
                rs1_rdy_r[free_idx_s] <= new_rs1_rdy_s;
                rs2_rdy_r[free_idx_s] <= new_rs2_rdy_s;
                age_r[free_idx_s]     <= occ_after_remove_s[AGE_W-1:0];
                pay_r[free_idx_s]     <= '{rob_id:  alloc_rob_id,
                                           rs1_phy: alloc_rs1_phy,
                                           rs2_phy: alloc_rs2_phy,
                                           rd_phy:  alloc_rd_phy,
                                           funct3:  alloc_funct3,
                                           funct7:  alloc_funct7,
                                           imm:     alloc_imm};
            end
            occupancy_r   <= occ_next_s;
            alloc_ready_r <= (occ_next_s != FULL_OCC);
            if (issue_load_s) begin
                issue_valid_r <= sel_found_s;
                if (sel_found_s) begin
                    issue_pay_r <= pay_r[sel_idx_s];
                end
            end
        end
    end

    // Flattened ages for the invariant checker.
    always_comb begin
        age_flat_s = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_flat_s[i*AGE_W +: AGE_W] = age_r[i];
        end
    end

    rs_issue_scheduler_chk #(
        .RS_DEPTH (RS_DEPTH),
        .AGE_W    (AGE_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid_r),
        .ages      (age_flat_s),
        .occupancy (occupancy_r)
    );

    assign alloc_ready   = alloc_ready_r;
    assign issue_valid   = issue_valid_r;
    assign issue_rob_id  = issue_pay_r.rob_id;
    assign issue_rs1_phy = issue_pay_r.rs1_phy;
    assign issue_rs2_phy = issue_pay_r.rs2_phy;
    assign issue_rd_phy  = issue_pay_r.rd_phy;
    assign issue_funct3  = issue_pay_r.funct3;
    assign issue_funct7  = issue_pay_r.funct7;
    assign issue_imm     = issue_pay_r.imm;
    assign occupancy     = occupancy_r;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: single-op vector table plus multi-cycle sequences,
// with a scoreboard of expected issue payloads compared on every FU transfer.

module tb_rs_issue_scheduler;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rob_id;
    logic [5:0]  alloc_rs1_phy;
    logic        alloc_rs1_rdy;
    logic [5:0]  alloc_rs2_phy;
    logic        alloc_rs2_rdy;
    logic [5:0]  alloc_rd_phy;
    logic [2:0]  alloc_funct3;
    logic [6:0]  alloc_funct7;
    logic [31:0] alloc_imm;
    logic [1:0]  wb_valid;
    logic [11:0] wb_preg;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rob_id;
    logic [5:0]  issue_rs1_phy;
    logic [5:0]  issue_rs2_phy;
    logic [5:0]  issue_rd_phy;
    logic [2:0]  issue_funct3;
    logic [6:0]  issue_funct7;
    logic [31:0] issue_imm;
    logic [3:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } exp_t;

    typedef struct {
        logic [4:0] rob;
        logic [5:0] rs1;
        logic       rs1_rdy;
        logic [5:0] rs2;
        logic       rs2_rdy;
        logic [1:0] wbv;
        logic [5:0] wb0;
        logic [5:0] wb1;
        logic       exp_issue;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    rs_issue_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_rob_id  (alloc_rob_id),
        .alloc_rs1_phy (alloc_rs1_phy),
        .alloc_rs1_rdy (alloc_rs1_rdy),
        .alloc_rs2_phy (alloc_rs2_phy),
        .alloc_rs2_rdy (alloc_rs2_rdy),
        .alloc_rd_phy  (alloc_rd_phy),
        .alloc_funct3  (alloc_funct3),
        .alloc_funct7  (alloc_funct7),
        .alloc_imm     (alloc_imm),
        .wb_valid      (wb_valid),
        .wb_preg       (wb_preg),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rob_id  (issue_rob_id),
        .issue_rs1_phy (issue_rs1_phy),
        .issue_rs2_phy (issue_rs2_phy),
        .issue_rd_phy  (issue_rd_phy),
        .issue_funct3  (issue_funct3),
        .issue_funct7  (issue_funct7),
        .issue_imm     (issue_imm),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one allocation offer; payload fields derived from the ROB id.
    task automatic drive_alloc(input logic [4:0] rob, input logic [5:0] rs1, input logic r1,
                               input logic [5:0] rs2, input logic r2, input logic push);
        exp_t e;
        alloc_valid   = 1'b1;
        alloc_rob_id  = rob;
        alloc_rs1_phy = rs1;
        alloc_rs1_rdy = r1;
        alloc_rs2_phy = rs2;
        alloc_rs2_rdy = r2;
        alloc_rd_phy  = 6'd32 + {1'b0, rob};
        alloc_funct3  = rob[2:0];
        alloc_funct7  = {2'b01, rob};
        alloc_imm     = 32'hA500_0000 | {27'd0, rob};
        if (push) begin
            e.rob = rob; e.rs1 = rs1; e.rs2 = rs2; e.rd = 6'd32 + {1'b0, rob};
            e.f3 = rob[2:0]; e.f7 = {2'b01, rob}; e.imm = 32'hA500_0000 | {27'd0, rob};
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        wb_valid    = 2'b00;
    endtask

    // Scoreboard: every FU transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_issue_rob", {27'd0, issue_rob_id}, 32'd999);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rob_id", {27'd0, issue_rob_id}, {27'd0, e.rob});
                chk("sb_rs1",    {26'd0, issue_rs1_phy}, {26'd0, e.rs1});
                chk("sb_rs2",    {26'd0, issue_rs2_phy}, {26'd0, e.rs2});
                chk("sb_rd",     {26'd0, issue_rd_phy}, {26'd0, e.rd});
                chk("sb_funct3", {29'd0, issue_funct3}, {29'd0, e.f3});
                chk("sb_funct7", {25'd0, issue_funct7}, {25'd0, e.f7});
                chk("sb_imm",    issue_imm, e.imm);
            end
        end
    end

    initial begin
        vecs[0] = '{rob: 5'd3, rs1: 6'd5,  rs1_rdy: 1'b1, rs2: 6'd6,  rs2_rdy: 1'b1, wbv: 2'b00, wb0: 6'd0,  wb1: 6'd0,  exp_issue: 1'b1};
        vecs[1] = '{rob: 5'd4, rs1: 6'd0,  rs1_rdy: 1'b0, rs2: 6'd0,  rs2_rdy: 1'b0, wbv: 2'b00, wb0: 6'd0,  wb1: 6'd0,  exp_issue: 1'b1};
        vecs[2] = '{rob: 5'd5, rs1: 6'd9,  rs1_rdy: 1'b0, rs2: 6'd0,  rs2_rdy: 1'b0, wbv: 2'b00, wb0: 6'd9,  wb1: 6'd9,  exp_issue: 1'b0};
        vecs[3] = '{rob: 5'd6, rs1: 6'd3,  rs1_rdy: 1'b1, rs2: 6'd17, rs2_rdy: 1'b0, wbv: 2'b10, wb0: 6'd0,  wb1: 6'd17, exp_issue: 1'b1};
        vecs[4] = '{rob: 5'd7, rs1: 6'd12, rs1_rdy: 1'b0, rs2: 6'd4,  rs2_rdy: 1'b1, wbv: 2'b01, wb0: 6'd12, wb1: 6'd0,  exp_issue: 1'b1};
        vecs[5] = '{rob: 5'd8, rs1: 6'd12, rs1_rdy: 1'b0, rs2: 6'd4,  rs2_rdy: 1'b1, wbv: 2'b10, wb0: 6'd12, wb1: 6'd13, exp_issue: 1'b0};
        vecs[6] = '{rob: 5'd9, rs1: 6'd20, rs1_rdy: 1'b0, rs2: 6'd21, rs2_rdy: 1'b0, wbv: 2'b11, wb0: 6'd20, wb1: 6'd21, exp_issue: 1'b1};
        vecs[7] = '{rob: 5'd2, rs1: 6'd20, rs1_rdy: 1'b0, rs2: 6'd21, rs2_rdy: 1'b1, wbv: 2'b00, wb0: 6'd20, wb1: 6'd0,  exp_issue: 1'b0};

        rst = 1'b1; flush = 1'b0; issue_ready = 1'b1;
        alloc_valid = 1'b0; alloc_rob_id = '0; alloc_rs1_phy = '0; alloc_rs1_rdy = 1'b0;
        alloc_rs2_phy = '0; alloc_rs2_rdy = 1'b0; alloc_rd_phy = '0; alloc_funct3 = '0;
        alloc_funct7 = '0; alloc_imm = '0; wb_valid = 2'b00; wb_preg = '0;

        // T1 reset
        step(); step();
        rst = 1'b0;
        chk("t1_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("t1_occupancy", {28'd0, occupancy}, 32'd0);
        chk("t1_alloc_ready", {31'd0, alloc_ready}, 32'd1);

        // Table: single allocation, optional same-cycle wakeup, issue expected at c+2 or never
        for (int v = 0; v < 8; v++) begin
            drive_alloc(vecs[v].rob, vecs[v].rs1, vecs[v].rs1_rdy, vecs[v].rs2, vecs[v].rs2_rdy,
                        vecs[v].exp_issue);
            wb_valid = vecs[v].wbv;
            wb_preg  = {vecs[v].wb1, vecs[v].wb0};
            step();
            idle_inputs();
            chk($sformatf("vec%0d_valid_c1", v), {31'd0, issue_valid}, 32'd0);
            chk($sformatf("vec%0d_occ_c1", v), {28'd0, occupancy}, 32'd1);
            step();
            chk($sformatf("vec%0d_valid_c2", v), {31'd0, issue_valid}, {31'd0, vecs[v].exp_issue});
            chk($sformatf("vec%0d_occ_c2", v), {28'd0, occupancy}, vecs[v].exp_issue ? 32'd0 : 32'd1);
            step();
            flush = 1'b1;
            step();
            flush = 1'b0;
        end

        // T3 age order with a later wakeup
        drive_alloc(5'd1, 6'd9, 1'b0, 6'd0, 1'b1, 1'b0);
        step();
        drive_alloc(5'd2, 6'd5, 1'b1, 6'd6, 1'b1, 1'b1);
        step();
        drive_alloc(5'd1, 6'd9, 1'b0, 6'd0, 1'b1, 1'b1);
        alloc_valid = 1'b0;
        wb_valid = 2'b01;
        wb_preg  = {6'd0, 6'd9};
        step();
        idle_inputs();
        chk("t3_first_valid", {31'd0, issue_valid}, 32'd1);
        chk("t3_first_rob", {27'd0, issue_rob_id}, 32'd2);
        step();
        chk("t3_second_valid", {31'd0, issue_valid}, 32'd1);
        chk("t3_second_rob", {27'd0, issue_rob_id}, 32'd1);
        step();
        chk("t3_done_valid", {31'd0, issue_valid}, 32'd0);
        chk("t3_done_occ", {28'd0, occupancy}, 32'd0);

        // T4 fill under backpressure, then drain in allocation order
        issue_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t4_ready_before_%0d", i), {31'd0, alloc_ready}, 32'd1);
            drive_alloc(5'd10 + 5'(i), 6'd1, 1'b1, 6'd2, 1'b1, 1'b1);
            step();
        end
        chk("t4_full_occ", {28'd0, occupancy}, 32'd8);
        chk("t4_full_ready", {31'd0, alloc_ready}, 32'd0);
        drive_alloc(5'd30, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
        step();
        idle_inputs();
        chk("t4_full_ignored_occ", {28'd0, occupancy}, 32'd8);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_stall_valid_%0d", i), {31'd0, issue_valid}, 32'd1);
            chk($sformatf("t4_stall_rob_%0d", i), {27'd0, issue_rob_id}, 32'd10);
            step();
        end
        issue_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            step();
        end
        chk("t4_drain_left", exp_q.size(), 32'd0);
        step();
        chk("t4_drain_occ", {28'd0, occupancy}, 32'd0);
        chk("t4_drain_valid", {31'd0, issue_valid}, 32'd0);

        // T6 flush with a stalled issue register and five waiting entries
        issue_ready = 1'b0;
        drive_alloc(5'd20, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(5'd21 + 5'(i), 6'd40, 1'b0, 6'd2, 1'b1, 1'b0);
            step();
        end
        idle_inputs();
        chk("t6_pre_occ", {28'd0, occupancy}, 32'd5);
        chk("t6_pre_valid", {31'd0, issue_valid}, 32'd1);
        flush = 1'b1;
        drive_alloc(5'd26, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
        wb_valid = 2'b01;
        wb_preg  = {6'd0, 6'd40};
        step();
        flush = 1'b0;
        idle_inputs();
        chk("t6_post_occ", {28'd0, occupancy}, 32'd0);
        chk("t6_post_valid", {31'd0, issue_valid}, 32'd0);
        issue_ready = 1'b1;
        step();
        step();
        chk("t6_dropped_valid", {31'd0, issue_valid}, 32'd0);
        chk("t6_dropped_occ", {28'd0, occupancy}, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
